// File: rtl/logic_gate_unit_if.sv
// Handshake bundle for logic_gate_unit.
// Producer and consumer sides share one interface; the unit is the slave.
interface logic_gate_unit_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [2:0]       op;
   logic             mode;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_y;
   logic             out_parity;
   logic [CNT_W-1:0] out_count;

   modport master (
      output in_valid, in_a, in_b, op, mode, in_last, out_ready,
      input  in_ready, out_valid, out_y, out_parity, out_count
   );

   modport slave (
      input  in_valid, in_a, in_b, op, mode, in_last, out_ready,
      output in_ready, out_valid, out_y, out_parity, out_count
   );
endinterface

// File: rtl/logic_gate_unit.sv
// Registered bitwise logic unit: per-pair ops or multi-beat reduction,
// with valid/ready flow control and a one-cycle registered result.
module logic_gate_unit #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input logic              clk,
   input logic              rst_n,
   logic_gate_unit_if.slave bus
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACCUM = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   logic [1:0]       r_state;
   logic [2:0]       r_op;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_y;
   logic [CNT_W-1:0] r_count;

   logic             w_in_ready;
   logic             w_fire;
   logic             w_first;
   logic [WIDTH-1:0] w_base;
   logic [CNT_W-1:0] w_cnt_inc;

   function automatic logic [WIDTH-1:0] f_pair(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b
   );
      logic [WIDTH-1:0] y;
      unique case (op)
         3'd0:    y = a & b;
         3'd1:    y = a | b;
         3'd2:    y = a ^ b;
         3'd3:    y = ~(a & b);
         3'd4:    y = ~(a | b);
         3'd5:    y = ~(a ^ b);
         3'd6:    y = a;
         default: y = ~a;
      endcase
      return y;
   endfunction

   // Inverting ops fold with their base op; inversion happens once at the end.
   function automatic logic [WIDTH-1:0] f_base(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] acc,
      input logic [WIDTH-1:0] a
   );
      logic [WIDTH-1:0] y;
      unique case (op)
         3'd0, 3'd3: y = acc & a;
         3'd1, 3'd4: y = acc | a;
         3'd2, 3'd5: y = acc ^ a;
         default:    y = a;
      endcase
      return y;
   endfunction

   function automatic logic [WIDTH-1:0] f_xform(
      input logic [2:0]       op,
      input logic [WIDTH-1:0] acc
   );
      logic [WIDTH-1:0] y;
      unique case (op)
         3'd3, 3'd4, 3'd5, 3'd7: y = ~acc;
         default:                y = acc;
      endcase
      return y;
   endfunction

   assign w_in_ready = (r_state != S_HOLD) || bus.out_ready;
   assign w_fire     = bus.in_valid && w_in_ready;
   assign w_first    = (r_state != S_ACCUM);
   assign w_base     = f_base(r_op, r_acc, bus.in_a);
   assign w_cnt_inc  = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_op    <= 3'd0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_y     <= '0;
         r_count <= '0;
      end else if (w_fire && w_first) begin
         if (!bus.mode) begin
            r_y     <= f_pair(bus.op, bus.in_a, bus.in_b);
            r_count <= CNT_W'(1);
            r_state <= S_HOLD;
         end else begin
            r_op  <= bus.op;
            r_acc <= bus.in_a;
            r_cnt <= CNT_W'(1);
            if (bus.in_last) begin
               r_y     <= f_xform(bus.op, bus.in_a);
               r_count <= CNT_W'(1);
               r_state <= S_HOLD;
            end else begin
               r_state <= S_ACCUM;
            end
         end
      end else if (w_fire) begin
         r_acc <= w_base;
         r_cnt <= w_cnt_inc;
         if (bus.in_last) begin
            r_y     <= f_xform(r_op, w_base);
            r_count <= w_cnt_inc;
            r_state <= S_HOLD;
         end
      end else if (r_state == S_HOLD && bus.out_ready) begin
         r_state <= S_IDLE;
      end
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.out_valid  = (r_state == S_HOLD);
   assign bus.out_y      = r_y;
   assign bus.out_parity = ^r_y;
   assign bus.out_count  = r_count;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed bench for logic_gate_unit: pair ops, reductions,
// backpressure, counter saturation and mid-burst reset.
module tb_logic_gate_unit;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   logic_gate_unit_if #(.WIDTH(8), .CNT_W(8)) bus ();

   logic_gate_unit #(.WIDTH(8), .CNT_W(8)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   logic [7:0] pair_exp [8];
   logic [7:0] bp_a     [4];
   logic [7:0] bp_y     [4];

   initial begin
      checks = 0;
      errors = 0;
      pair_exp = '{8'hC0, 8'hFC, 8'h3C, 8'h3F, 8'h03, 8'hC3, 8'hF0, 8'h0F};
      bp_a     = '{8'h11, 8'h22, 8'h33, 8'h44};
      bp_y     = '{8'h1E, 8'h2D, 8'h3C, 8'h4B};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = 8'h00;
      bus.in_b      = 8'h00;
      bus.op        = 3'd0;
      bus.mode      = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      tick();
      chk("rst_valid", bus.out_valid, 1'b0);
      chk("rst_y", bus.out_y, 8'h00);
      chk("rst_par", bus.out_parity, 1'b0);
      chk("rst_cnt", bus.out_count, 8'd0);
      chk("rst_rdy", bus.in_ready, 1'b1);
      tick();
      rst_n = 1'b1;
      tick();

      // Pair mode, every op, back to back
      bus.out_ready = 1'b1;
      bus.mode      = 1'b0;
      bus.in_a      = 8'hF0;
      bus.in_b      = 8'hCC;
      bus.in_valid  = 1'b1;
      chk("pair_pre_valid", bus.out_valid, 1'b0);
      for (int i = 0; i < 8; i++) begin
         bus.op = 3'(i);
         tick();
         chk($sformatf("pair_y%0d", i), bus.out_y, pair_exp[i]);
         chk($sformatf("pair_v%0d", i), bus.out_valid, 1'b1);
         chk($sformatf("pair_c%0d", i), bus.out_count, 8'd1);
         chk($sformatf("pair_p%0d", i), bus.out_parity, ^pair_exp[i]);
      end
      bus.in_valid = 1'b0;
      tick();
      chk("pair_drain", bus.out_valid, 1'b0);

      // Reduce AND over FF,0F,3C then NAND over the same beats
      bus.mode     = 1'b1;
      bus.op       = 3'd0;
      bus.in_valid = 1'b1;
      bus.in_a     = 8'hFF;
      bus.in_last  = 1'b0;
      tick();
      chk("and_mid_valid", bus.out_valid, 1'b0);
      chk("and_mid_rdy", bus.in_ready, 1'b1);
      bus.in_a = 8'h0F;
      tick();
      bus.in_a    = 8'h3C;
      bus.in_last = 1'b1;
      tick();
      chk("and_y", bus.out_y, 8'h0C);
      chk("and_cnt", bus.out_count, 8'd3);
      chk("and_par", bus.out_parity, 1'b0);
      chk("and_valid", bus.out_valid, 1'b1);
      bus.op      = 3'd3;
      bus.in_a    = 8'hFF;
      bus.in_last = 1'b0;
      tick();
      bus.op   = 3'd0;
      bus.in_a = 8'h0F;
      tick();
      bus.in_a    = 8'h3C;
      bus.in_last = 1'b1;
      tick();
      chk("nand_y", bus.out_y, 8'hF3);
      chk("nand_cnt", bus.out_count, 8'd3);
      chk("nand_par", bus.out_parity, 1'b0);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      tick();

      // Backpressure on the second result of a 4-beat XOR pair stream
      bus.mode     = 1'b0;
      bus.op       = 3'd2;
      bus.in_b     = 8'h0F;
      bus.in_valid = 1'b1;
      bus.in_a     = bp_a[0];
      tick();
      chk("bp_y0", bus.out_y, bp_y[0]);
      bus.in_a = bp_a[1];
      tick();
      chk("bp_y1", bus.out_y, bp_y[1]);
      bus.in_a      = bp_a[2];
      bus.out_ready = 1'b0;
      #1;
      chk("bp_rdy_low", bus.in_ready, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("bp_hold_y%0d", i), bus.out_y, bp_y[1]);
         chk($sformatf("bp_hold_v%0d", i), bus.out_valid, 1'b1);
         chk($sformatf("bp_hold_r%0d", i), bus.in_ready, 1'b0);
      end
      bus.out_ready = 1'b1;
      tick();
      chk("bp_y2", bus.out_y, bp_y[2]);
      bus.in_a = bp_a[3];
      tick();
      chk("bp_y3", bus.out_y, bp_y[3]);
      chk("bp_c3", bus.out_count, 8'd1);
      bus.in_valid = 1'b0;
      tick();
      chk("bp_drain", bus.out_valid, 1'b0);

      // 302-beat XOR reduce of 01/03; op switched to AND mid-burst
      bus.mode     = 1'b1;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 302; i++) begin
         bus.op      = (i >= 150) ? 3'd0 : 3'd2;
         bus.in_a    = (i % 2 == 1) ? 8'h03 : 8'h01;
         bus.in_b    = 8'(i);
         bus.in_last = (i == 301);
         tick();
      end
      chk("sat_y", bus.out_y, 8'h02);
      chk("sat_cnt", bus.out_count, 8'd255);
      chk("sat_par", bus.out_parity, 1'b1);
      chk("sat_valid", bus.out_valid, 1'b1);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      tick();

      // Reset on beat 2 of a 4-beat OR reduce
      bus.op       = 3'd1;
      bus.in_valid = 1'b1;
      bus.in_a     = 8'h11;
      tick();
      bus.in_a = 8'h22;
      rst_n    = 1'b0;
      #1;
      chk("mrst_valid", bus.out_valid, 1'b0);
      chk("mrst_cnt", bus.out_count, 8'd0);
      chk("mrst_rdy", bus.in_ready, 1'b1);
      bus.in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("mrst_quiet%0d", i), bus.out_valid, 1'b0);
      end
      bus.in_valid = 1'b1;
      bus.in_a     = 8'h5A;
      bus.in_last  = 1'b1;
      tick();
      chk("or1_y", bus.out_y, 8'h5A);
      chk("or1_cnt", bus.out_count, 8'd1);
      chk("or1_par", bus.out_parity, 1'b0);
      chk("or1_valid", bus.out_valid, 1'b1);
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      tick();
      chk("or1_drain", bus.out_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
